// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the system RAM arbiter.
package ram_arb_pkg;

    localparam int unsigned ADDR_W_DEF     = 16;
    localparam int unsigned DATA_W_DEF     = 8;
    localparam int unsigned FIFO_DEPTH_DEF = 4;
    localparam logic [7:0]  FILL_VALUE_DEF = 8'hFF;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } ld_entry_t;

endpackage

// File: rtl/ram_arb_fifo.sv
// Small synchronous FIFO buffering download writes until the RAM has a free cycle.
module ram_arb_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 24
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           rd_data_c,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] store_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             do_push;
    logic             do_pop;

    // A push while full is only taken when a pop frees the slot in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
            full    <= (count_d == CNT_W'(DEPTH));
            empty   <= (count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) store_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data_c = store_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-port system RAM between the CPU bus, buffered download
// writes and a clear-fill engine that owns the RAM after reset.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned        ADDR_W     = ADDR_W_DEF,
    parameter int unsigned        DATA_W     = DATA_W_DEF,
    parameter int unsigned        FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter logic [DATA_W-1:0]  FILL_VALUE = DATA_W'(FILL_VALUE_DEF)
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              clr_start,
    output logic              clr_busy,
    input  logic              cpu_cs,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    output logic [DATA_W-1:0] cpu_dout,
    input  logic              ld_wr,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_full,
    output logic              ld_idle,
    output logic              ld_overflow,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_q
);

    localparam int unsigned ENTRY_W = ADDR_W + DATA_W;
    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;

    arb_state_e        state_q;
    arb_state_e        state_d;
    logic [ADDR_W-1:0] clr_cnt_q;
    logic [ADDR_W-1:0] clr_cnt_d;

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [ENTRY_W-1:0] fifo_head;
    logic [ADDR_W-1:0]  head_addr;
    logic [DATA_W-1:0]  head_data;

    assign fifo_push = ld_wr && (!fifo_full || fifo_pop);
    assign head_addr = fifo_head[DATA_W +: ADDR_W];
    assign head_data = fifo_head[DATA_W-1:0];

    ram_arb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk_sys),
        .rst_n     (reset_n),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .wr_data   ({ld_addr, ld_data}),
        .rd_data_c (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Ownership and memory-side muxing; the RAM sees no added latency.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        mem_addr  = cpu_addr;
        mem_din   = cpu_din;
        mem_we    = 1'b0;
        fifo_pop  = 1'b0;
        case (state_q)
            CLEAR: begin
                mem_addr  = clr_cnt_q;
                mem_din   = FILL_VALUE;
                // Held off while in reset so the sweep begins on the first edge after release.
                mem_we    = reset_n;
                clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                if (clr_start) begin
                    clr_cnt_d = '0;
                end else if (clr_cnt_q == {ADDR_W{1'b1}}) begin
                    state_d = IDLE;
                end
            end
            default: begin
                if (clr_start) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end
                if (cpu_cs) begin
                    mem_we = cpu_we;
                end else if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    mem_addr = head_addr;
                    mem_din  = head_data;
                    mem_we   = 1'b1;
                end
            end
        endcase
    end

    // Overflow is sticky until reset so firmware can detect any lost byte.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ld_overflow <= 1'b0;
        end else if (ld_wr && fifo_full && !fifo_pop) begin
            ld_overflow <= 1'b1;
        end
    end

    assign clr_busy = (state_q == CLEAR);
    assign ld_full  = fifo_full;
    assign ld_idle  = (fifo_count == '0) && !ld_wr;
    assign cpu_dout = mem_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios then random traffic,
// checked cycle by cycle against a queue-based ownership model and a RAM image.
module tb_ram_arbiter;

    localparam int unsigned AW    = 8;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned N     = 1 << AW;

    logic          clk_sys = 1'b0;
    logic          reset_n;
    logic          clr_start;
    logic          clr_busy;
    logic          cpu_cs;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_din;
    logic [DW-1:0] cpu_dout;
    logic          ld_wr;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          ld_full;
    logic          ld_idle;
    logic          ld_overflow;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic          mem_we;
    logic [DW-1:0] mem_q;

    always #5 clk_sys = ~clk_sys;

    ram_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .FIFO_DEPTH (DEPTH),
        .FILL_VALUE (8'hFF)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .clr_start   (clr_start),
        .clr_busy    (clr_busy),
        .cpu_cs      (cpu_cs),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_din     (cpu_din),
        .cpu_dout    (cpu_dout),
        .ld_wr       (ld_wr),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .ld_full     (ld_full),
        .ld_idle     (ld_idle),
        .ld_overflow (ld_overflow),
        .mem_addr    (mem_addr),
        .mem_din     (mem_din),
        .mem_we      (mem_we),
        .mem_q       (mem_q)
    );

    // Single-port RAM with registered read data.
    logic [DW-1:0] ram [N];
    always @(posedge clk_sys) begin
        if (mem_we) ram[mem_addr] <= mem_din;
        mem_q <= ram[mem_addr];
    end

    // Reference model state
    bit            m_clear;
    int            m_caddr;
    bit            m_ovf;
    int            q_addr[$];
    int            q_data[$];
    logic [DW-1:0] ref_mem [N];
    bit            rd_pend;
    logic [DW-1:0] rd_exp;

    int total;
    int bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check the current cycle at the falling edge, advance the model, then move past the rising edge.
    task automatic step();
        logic          exp_we;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_din;
        @(negedge clk_sys);
        chk("clr_busy",    32'(clr_busy),    32'(m_clear));
        chk("ld_full",     32'(ld_full),     32'(q_addr.size() == DEPTH));
        chk("ld_idle",     32'(ld_idle),     32'(q_addr.size() == 0 && !ld_wr));
        chk("ld_overflow", 32'(ld_overflow), 32'(m_ovf));
        if (rd_pend) chk("cpu_dout", 32'(cpu_dout), 32'(rd_exp));
        rd_pend = 1'b0;

        exp_din = '0;
        if (m_clear) begin
            exp_we   = 1'b1;
            exp_addr = AW'(m_caddr);
            exp_din  = 8'hFF;
        end else if (cpu_cs) begin
            exp_we   = cpu_we;
            exp_addr = cpu_addr;
            exp_din  = cpu_din;
            if (!cpu_we) begin
                rd_pend = 1'b1;
                rd_exp  = ref_mem[cpu_addr];
            end
        end else if (q_addr.size() > 0) begin
            exp_we   = 1'b1;
            exp_addr = AW'(q_addr.pop_front());
            exp_din  = DW'(q_data.pop_front());
        end else begin
            exp_we   = 1'b0;
            exp_addr = cpu_addr;
        end

        chk("mem_we",   32'(mem_we),   32'(exp_we));
        chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
        if (exp_we) begin
            chk("mem_din", 32'(mem_din), 32'(exp_din));
            ref_mem[exp_addr] = exp_din;
        end

        if (ld_wr) begin
            if (q_addr.size() < DEPTH) begin
                q_addr.push_back(int'(ld_addr));
                q_data.push_back(int'(ld_data));
            end else begin
                m_ovf = 1'b1;
            end
        end

        if (m_clear) begin
            if (clr_start)              m_caddr = 0;
            else if (m_caddr == N - 1)  m_clear = 1'b0;
            else                        m_caddr++;
        end else if (clr_start) begin
            m_clear = 1'b1;
            m_caddr = 0;
        end

        @(posedge clk_sys);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < N; i++) begin
            ram[i]     = '0;
            ref_mem[i] = '0;
        end
        m_clear   = 1'b1;
        m_caddr   = 0;
        m_ovf     = 1'b0;
        rd_pend   = 1'b0;
        reset_n   = 1'b0;
        clr_start = 1'b0;
        cpu_cs    = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_din   = '0;
        ld_wr     = 1'b0;
        ld_addr   = '0;
        ld_data   = '0;

        #23;
        chk("rst_clr_busy",    32'(clr_busy),    32'd1);
        chk("rst_mem_we",      32'(mem_we),      32'd0);
        chk("rst_mem_addr",    32'(mem_addr),    32'd0);
        chk("rst_mem_din",     32'(mem_din),     32'hFF);
        chk("rst_ld_full",     32'(ld_full),     32'd0);
        chk("rst_ld_idle",     32'(ld_idle),     32'd1);
        chk("rst_ld_overflow", 32'(ld_overflow), 32'd0);
        @(posedge clk_sys);
        #1;
        reset_n = 1'b1;

        // Power-on clear sweep
        repeat (N) step();
        cpu_cs = 1'b1; cpu_addr = 8'h34; step();
        cpu_cs = 1'b0; step();

        // CPU write then read back
        cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h10; cpu_din = 8'h5A; step();
        cpu_we = 1'b0; step();
        cpu_cs = 1'b0; step();

        // Fill FIFO under CPU ownership, then push into the slot freed by a pop
        cpu_cs = 1'b1; cpu_addr = 8'h40;
        for (int i = 0; i < 4; i++) begin
            ld_wr = 1'b1; ld_addr = AW'(8'h20 + i); ld_data = DW'(i + 1); step();
        end
        ld_wr = 1'b0; step();
        cpu_cs = 1'b0; ld_wr = 1'b1; ld_addr = 8'h24; ld_data = 8'h05; step();
        ld_wr = 1'b0;
        repeat (5) step();
        chk("ram_0124", 32'(ram[8'h24]), 32'h05);

        // Fifth push into a full FIFO with no pop is dropped
        cpu_cs = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ld_wr = 1'b1; ld_addr = AW'(8'h30 + i); ld_data = DW'(8'h11 * (i + 1)); step();
        end
        ld_wr = 1'b0; cpu_cs = 1'b0;
        repeat (5) step();
        chk("ram_dropped", 32'(ram[8'h34]), 32'hFF);
        chk("ram_0133",    32'(ram[8'h33]), 32'h44);

        // Clear, restart half way, with pushes held until the sweep ends
        clr_start = 1'b1; step();
        clr_start = 1'b0;
        repeat (N / 2) step();
        clr_start = 1'b1; step();
        clr_start = 1'b0;
        ld_wr = 1'b1; ld_addr = 8'h50; ld_data = 8'hA5; step();
        ld_addr = 8'h51; ld_data = 8'h5A; step();
        ld_wr = 1'b0;
        repeat (N) step();
        repeat (4) step();
        chk("ram_0150", 32'(ram[8'h50]), 32'hA5);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            cpu_cs    = ($urandom % 100) < 40;
            cpu_we    = $urandom % 2;
            cpu_addr  = AW'($urandom);
            cpu_din   = DW'($urandom);
            ld_wr     = ($urandom % 100) < 35;
            ld_addr   = AW'($urandom);
            ld_data   = DW'($urandom);
            clr_start = ($urandom % 1000) == 0;
            step();
        end
        cpu_cs = 1'b0; cpu_we = 1'b0; ld_wr = 1'b0; clr_start = 1'b0;
        repeat (N + 10) step();

        for (int a = 0; a < N; a++) begin
            chk("ram_image", 32'(ram[a]), 32'(ref_mem[a]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
